id_ex_stage_reg: RTL

//  ID/EX pipeline register with integrated load-use hazard detection. Latches decoded
//  ID-stage fields and controls into EX. These registered outputs feed the EX-stage

---
 rtl/id_ex_stage_reg.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage_reg.sv
// ----------------------------------------------------------------------------
// id_ex_stage_reg
//   ID/EX pipeline register with built-in load-use hazard detection.
//   Captures decoded ID-stage fields and controls for the EX stage. It inserts
//   a single bubble when the instruction in ID needs the result of a load
//   that is currently in EX, and it asks the front end to hold PC and IF/ID
//   for that cycle. A branch/jump flush squashes the transfer into EX, and
//   Ex_Hold freezes the whole register.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   If_O_Id_Rs1/Rs2            ID-stage source register indices
//   Id_opcode/funct3/funct7    ID-stage decode fields
//   Id_Rd                      ID-stage destination register
//   Id_pc/imm/rs1_data/rs2_data  ID-stage datapath values (XLEN)
//   Id_ctrl                    {RegWrite,MemRead,MemWrite,MemtoReg,ALUSrc,
//                               Branch,Jump,ALUOp[1:0]}
//   Id_valid                   ID slot holds a real instruction
//   Flush                      squash the ID->EX transfer
//   Ex_Hold                    freeze this register (MEM not ready)
//   Id_Out_Ex_*                registered copies of the ID fields
//   Id_O_Ex_MemRead/MemWrite   registered MemRead/MemWrite control bits
//   Stall_PC, Stall_IF_ID      hold PC / IF/ID this cycle
//   Stall_cnt, Flush_cnt       wrap-around bubble and flush event counters
// ----------------------------------------------------------------------------
module id_ex_stage_reg #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      If_O_Id_Rs1,
    input  logic [4:0]      If_O_Id_Rs2,
    input  logic [6:0]      Id_opcode,
    input  logic [2:0]      Id_funct3,
    input  logic [6:0]      Id_funct7,
    input  logic [4:0]      Id_Rd,
    input  logic [XLEN-1:0] Id_pc,
    input  logic [XLEN-1:0] Id_imm,
    input  logic [XLEN-1:0] Id_rs1_data,
    input  logic [XLEN-1:0] Id_rs2_data,
    input  logic [8:0]      Id_ctrl,
    input  logic            Id_valid,
    input  logic            Flush,
    input  logic            Ex_Hold,
    output logic [4:0]      Id_Out_Ex_Rs1,
    output logic [4:0]      Id_Out_Ex_Rs2,
    output logic [6:0]      Id_Out_Ex_opcode,
    output logic [2:0]      Id_Out_Ex_funct3,
    output logic [6:0]      Id_Out_Ex_funct7,
    output logic [4:0]      Id_Out_Ex_Rd,
    output logic [XLEN-1:0] Id_Out_Ex_pc,
    output logic [XLEN-1:0] Id_Out_Ex_imm,
    output logic [XLEN-1:0] Id_Out_Ex_rs1_data,
    output logic [XLEN-1:0] Id_Out_Ex_rs2_data,
    output logic [8:0]      Id_Out_Ex_ctrl,
    output logic            Id_Out_Ex_valid,
    output logic            Id_O_Ex_MemRead,
    output logic            Id_O_Ex_MemWrite,
    output logic            Stall_PC,
    output logic            Stall_IF_ID,
    output logic [CNT_W-1:0] Stall_cnt,
    output logic [CNT_W-1:0] Flush_cnt
);

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;

    typedef struct packed {
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      rd;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [8:0]      ctrl;
        logic            valid;
    } ex_t;

    ex_t             ex_q, ex_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic uses_rs1, uses_rs2, is_store;
    logic dep_rs1, dep_rs2, lu, stall;

    always_comb begin
        uses_rs1 = !(Id_opcode == OP_LUI || Id_opcode == OP_AUIPC || Id_opcode == OP_JAL);
        uses_rs2 = (Id_opcode == OP_R) || (Id_opcode == OP_S) || (Id_opcode == OP_B);
        is_store = (Id_opcode == OP_S);

        dep_rs1 = uses_rs1 && (ex_q.rd == If_O_Id_Rs1);
        // A store's data operand (rs2) can be forwarded mem-to-mem from the
        // load, so that dependency alone does not need a bubble.
        dep_rs2 = uses_rs2 && !is_store && (ex_q.rd == If_O_Id_Rs2);

        lu    = ex_q.valid && ex_q.ctrl[7] && (ex_q.rd != 5'd0) && Id_valid &&
                (dep_rs1 || dep_rs2);
        stall = (lu && !Flush) || Ex_Hold;
    end

    always_comb begin
        ex_d        = ex_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (Ex_Hold) begin
            ex_d = ex_q;
        end else if (Flush) begin
            ex_d        = '0;
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end else if (lu) begin
            ex_d        = '0;
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            ex_d.rs1      = If_O_Id_Rs1;
            ex_d.rs2      = If_O_Id_Rs2;
            ex_d.opcode   = Id_opcode;
            ex_d.funct3   = Id_funct3;
            ex_d.funct7   = Id_funct7;
            ex_d.rd       = Id_Rd;
            ex_d.pc       = Id_pc;
            ex_d.imm      = Id_imm;
            ex_d.rs1_data = Id_rs1_data;
            ex_d.rs2_data = Id_rs2_data;
            ex_d.ctrl     = Id_ctrl;
            ex_d.valid    = Id_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign Id_Out_Ex_Rs1      = ex_q.rs1;
    assign Id_Out_Ex_Rs2      = ex_q.rs2;
    assign Id_Out_Ex_opcode   = ex_q.opcode;
    assign Id_Out_Ex_funct3   = ex_q.funct3;
    assign Id_Out_Ex_funct7   = ex_q.funct7;
    assign Id_Out_Ex_Rd       = ex_q.rd;
    assign Id_Out_Ex_pc       = ex_q.pc;
    assign Id_Out_Ex_imm      = ex_q.imm;
    assign Id_Out_Ex_rs1_data = ex_q.rs1_data;
    assign Id_Out_Ex_rs2_data = ex_q.rs2_data;
    assign Id_Out_Ex_ctrl     = ex_q.ctrl;
    assign Id_Out_Ex_valid    = ex_q.valid;
    assign Id_O_Ex_MemRead    = ex_q.ctrl[7];
    assign Id_O_Ex_MemWrite   = ex_q.ctrl[6];
    assign Stall_PC           = stall;
    assign Stall_IF_ID        = stall;
    assign Stall_cnt          = stall_cnt_q;
    assign Flush_cnt          = flush_cnt_q;

endmodule
